conv_window_sched: RTL and testbench
====================================

Name: conv_window_sched

Overview:
Sequencer for the 3x3 convolution datapath. It streams a 28x28 8-bit image out of the image buffer RAM in row-major order, one pixel per read. It keeps a two-row line buffer plus a 3x3 window register, and hands each interior 3x3 window, with its output address, to the MAC engine over a valid/ready handshake. It sits between the image buffer RAM and the conv MAC/writeback unit, and owns start/busy/done for one convolution pass.

Parameters:
IMG_W, 28, image width in pixels (minimum 3)
IMG_H, 28, image height in pixels (minimum 3)
PIX_W, 8, pixel width in bits
ADDR_W, 10, address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a pass; ignored unless IDLE
busy  out  1  high while a pass is in progress
done  out  1  one-cycle pulse when the last window is accepted
mem_rd_en  out  1  image RAM read strobe
mem_rd_addr  out  ADDR_W  image RAM read address, row-major r*IMG_W+c
mem_rd_data  in  PIX_W  read data, valid exactly 1 cycle after mem_rd_en
mac_valid  out  1  window/address valid to MAC engine
mac_ready  in  1  MAC engine accepts when mac_valid && mac_ready
mac_window  out  9*PIX_W  taps; tap k at [k*PIX_W +: PIX_W], k=3*dy+dx, dy/dx 0..2 top-left to bottom-right
mac_addr  out  ADDR_W  output address of window centre, (r-1)*IMG_W+(c-1)
win_count  out  ADDR_W  windows accepted in current/last pass

Behaviour:
- Reset (rst=1 at edge): state IDLE. busy, done, mem_rd_en, mac_valid = 0. mem_rd_addr, mac_window, mac_addr, win_count = 0. Line buffer contents are don't-care.
- Reset mid-pass: same as above on the next edge. No done pulse. In-flight read data is discarded.
- States: IDLE -> RUN on start. RUN -> DRAIN after read of pixel IMG_W*IMG_H-1 is issued. DRAIN -> IDLE once the final window is accepted; done pulses that cycle.
- start sampled at edge 0. busy=1 from cycle 1 through the done cycle inclusive, 0 after. win_count clears to 0 at cycle 1.
- Read issue rules:
  - In RUN, issue one read per cycle at ascending addresses from 0.
  - Suspend issue in any cycle where mac_valid=1 and mac_ready=0. Any already in-flight word is held in a one-entry skid register, so no pixel is lost or re-read.
- Arriving pixel (r,c):
  - Shifts into the line buffer.
  - The window column shifts left; the new column is {line[r-2][c], line[r-1][c], pixel}.
  - If r>=2 and c>=2, a window is registered the next cycle with mac_valid=1 and mac_addr=(r-1)*IMG_W+(c-1).
  - Columns 0 and 1 of each row produce no window (row-wrap gap). Border output addresses are never issued.
- Handshake:
  - mac_window and mac_addr are stable while mac_valid=1 and mac_ready=0.
  - mac_valid drops the cycle after acceptance unless the next window is ready.
  - win_count increments on each acceptance.
- Total windows per pass = (IMG_W-2)*(IMG_H-2) = 676 at defaults.
- Latency with mac_ready tied 1 (defaults):
  - Reads at cycles 1..784; pixel p data at cycle p+2.
  - First window (centre addr 29) mac_valid at cycle 61.
  - Last window (addr 754) at cycle 786; done pulse at cycle 786.
- start during busy: ignored, no effect on counters.
- start coincident with rst: rst wins.
- start in the cycle after done: accepted, back-to-back passes allowed.
- Arithmetic: address counters are unsigned. Row/col counters wrap col at IMG_W-1 to 0 and increment row. No pixel arithmetic is done in this block.

Test Plan:
1. Ramp image mem[p]=p mod 256, mac_ready=1, start at cycle 0 -> first mac_valid at cycle 61, addr 29, taps {0,1,2,28,29,30,56,57,58}; 676 windows; last addr 754, taps {725,726,727,753,754,755,781,782,783} mod 256; done at cycle 786, win_count=676.
2. Ramp image, mac_ready pseudo-random 50% -> window sequence and taps identical to scenario 1 in order; mac_window/mac_addr never change while stalled; no mem_rd_en issued during stall except the one in flight.
3. start pulsed again at cycles 100 and 400 of a running pass -> ignored; exactly one done; win_count=676.
4. rst asserted at cycle 300, then start at 310 -> all outputs 0 at cycle 301; no done from the first pass; the second pass is fully correct with first window at cycle 371.
5. Two passes back-to-back (start at the cycle after done) with constant image 8'hFF then 8'h01 -> every tap of pass 1 is FF; every tap of pass 2 is 01; no stale FF taps in pass 2.
6. IMG_W=5, IMG_H=4 parameter override, ramp image -> 6 windows, addrs {6,7,8,11,12,13}, first taps {0,1,2,5,6,7,10,11,12}.

Source files
------------

// File: rtl/conv_window_sched.sv
// rtl/conv_window_sched.sv - 3x3 convolution window sequencer (image RAM -> MAC engine)
//
// Streams an IMG_W x IMG_H image out of the image RAM in row-major order,
// maintains a two-row line buffer plus a 3x3 tap register, and presents each
// interior window with its centre address to the MAC engine.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle pass request, honoured only when idle
//   busy, done            pass in progress / one-cycle end-of-pass pulse
//   mem_rd_en/addr/data   image RAM read port (data returns one cycle later)
//   mac_valid/ready       window handshake to the MAC engine
//   mac_window            9 taps, tap k = 3*dy+dx at [k*PIX_W +: PIX_W]
//   mac_addr              output address of the window centre
//   win_count             windows accepted in the current/last pass
module conv_window_sched #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 mem_rd_en,
   output logic [ADDR_W-1:0]    mem_rd_addr,
   input  logic [PIX_W-1:0]     mem_rd_data,
   output logic                 mac_valid,
   input  logic                 mac_ready,
   output logic [9*PIX_W-1:0]   mac_window,
   output logic [ADDR_W-1:0]    mac_addr,
   output logic [ADDR_W-1:0]    win_count
);
   localparam int COL_W = $clog2(IMG_W);
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W*IMG_H-1);
   localparam logic [ADDR_W-1:0] LAST_WIN = ADDR_W'((IMG_W-2)*(IMG_H-2)-1);
   localparam logic [ADDR_W-1:0] CTR_OFS  = ADDR_W'(IMG_W+1);
   localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
   localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W-1);
   localparam logic [COL_W-1:0]  C_ONE    = COL_W'(1);
   localparam logic [COL_W-1:0]  C_TWO    = COL_W'(2);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
   state_t r_state, w_next;

   logic [PIX_W-1:0]  r_line1 [2**COL_W];   // row r-1
   logic [PIX_W-1:0]  r_line2 [2**COL_W];   // row r-2
   logic [PIX_W-1:0]  r_tap   [9];
   logic [COL_W-1:0]  r_col;
   logic [1:0]        r_row;                // saturates at 2: only "r>=2" matters
   logic [ADDR_W-1:0] r_pix_idx;            // index of the next pixel to consume
   logic              r_rd_pend;            // read issued last cycle, data on mem_rd_data now
   logic              r_skid_valid;
   logic [PIX_W-1:0]  r_skid_data;

   logic              w_stall, w_accept, w_consume, w_is_win;
   logic [PIX_W-1:0]  w_pix;

   assign w_stall   = mac_valid && !mac_ready;
   assign w_accept  = mac_valid && mac_ready;
   // Pixels are only consumed when the output slot is free or being freed,
   // so a stalled window is never overwritten.
   assign w_consume = (r_rd_pend || r_skid_valid) && !w_stall;
   assign w_pix     = r_skid_valid ? r_skid_data : mem_rd_data;
   assign w_is_win  = (r_row == 2'd2) && (r_col >= C_TWO);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (mem_rd_en && mem_rd_addr == LAST_PIX) w_next = S_DRAIN;
         S_DRAIN: if (done) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state != S_IDLE);
      mem_rd_en = (r_state == S_RUN) && !w_stall;
      // The last window needs the last pixel, so it is always accepted in DRAIN.
      done      = (r_state == S_DRAIN) && w_accept && (win_count == LAST_WIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_rd_addr  <= '0;
         mac_valid    <= 1'b0;
         mac_addr     <= '0;
         win_count    <= '0;
         r_rd_pend    <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_pix_idx    <= '0;
         for (int k = 0; k < 9; k++) r_tap[k] <= '0;
      end else begin
         r_rd_pend <= mem_rd_en;
         if (r_state == S_IDLE && start) begin
            mem_rd_addr  <= '0;
            win_count    <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_pix_idx    <= '0;
            r_skid_valid <= 1'b0;
         end else begin
            if (mem_rd_en) mem_rd_addr <= mem_rd_addr + A_ONE;
            if (w_accept)  win_count   <= win_count + A_ONE;
            // A word landing during a stall parks in the skid register.
            if (r_rd_pend && !w_consume) begin
               r_skid_data  <= mem_rd_data;
               r_skid_valid <= 1'b1;
            end else if (w_consume) begin
               r_skid_valid <= 1'b0;
            end
            if (w_consume) begin
               mac_valid <= w_is_win;
               if (w_is_win) mac_addr <= r_pix_idx - CTR_OFS;
               for (int dy = 0; dy < 3; dy++) begin
                  r_tap[3*dy]   <= r_tap[3*dy+1];
                  r_tap[3*dy+1] <= r_tap[3*dy+2];
               end
               r_tap[2]  <= r_line2[r_col];
               r_tap[5]  <= r_line1[r_col];
               r_tap[8]  <= w_pix;
               r_pix_idx <= r_pix_idx + A_ONE;
               if (r_col == LAST_COL) begin
                  r_col <= '0;
                  if (r_row != 2'd2) r_row <= r_row + 2'd1;
               end else begin
                  r_col <= r_col + C_ONE;
               end
            end else if (w_accept) begin
               mac_valid <= 1'b0;
            end
         end
      end
   end

   // Line buffer contents need no reset: rows are refilled before use each pass.
   always_ff @(posedge clk) begin
      if (w_consume) begin
         r_line2[r_col] <= r_line1[r_col];
         r_line1[r_col] <= w_pix;
      end
   end

   always_comb begin
      mac_window = '0;
      for (int k = 0; k < 9; k++) mac_window[k*PIX_W +: PIX_W] = r_tap[k];
   end
endmodule

// File: tb/tb_conv_window_sched.sv
// tb/tb_conv_window_sched.sv - scoreboard bench for conv_window_sched
module tb_conv_window_sched;
   localparam int W = 28, H = 28, PW = 8, AW = 10;
   localparam int NWIN = (W-2)*(H-2);
   localparam int SW = 5, SH = 4;

   typedef struct {
      logic [AW-1:0]   addr;
      logic [9*PW-1:0] win;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, start, busy, done, mem_rd_en, mac_valid, mac_ready;
   logic [AW-1:0]  mem_rd_addr, mac_addr, win_count;
   logic [PW-1:0]  mem_rd_data;
   logic [9*PW-1:0] mac_window;

   logic           s_rst, s_start, s_busy, s_done, s_rd_en, s_valid, s_ready;
   logic [AW-1:0]  s_rd_addr, s_addr, s_win_count;
   logic [PW-1:0]  s_rd_data;
   logic [9*PW-1:0] s_window;

   conv_window_sched #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_window(mac_window),
      .mac_addr(mac_addr), .win_count(win_count));

   conv_window_sched #(.IMG_W(SW), .IMG_H(SH), .PIX_W(PW), .ADDR_W(AW)) dut_s (
      .clk(clk), .rst(s_rst), .start(s_start), .busy(s_busy), .done(s_done),
      .mem_rd_en(s_rd_en), .mem_rd_addr(s_rd_addr), .mem_rd_data(s_rd_data),
      .mac_valid(s_valid), .mac_ready(s_ready), .mac_window(s_window),
      .mac_addr(s_addr), .win_count(s_win_count));

   logic [PW-1:0] img [1<<AW];
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= img[mem_rd_addr];
   always @(posedge clk) if (s_rd_en) s_rd_data <= s_rd_addr[PW-1:0];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_chk = 0, n_pass = 0;
   int   t0 = 0, first_rel = -1, done_rel = -1, done_cnt = 0;
   bit   rand_ready = 0;
   bit   prev_stall = 0;
   logic [9*PW-1:0] prev_win;
   logic [AW-1:0]   prev_addr;
   exp_t q[$];
   exp_t sq[$];

   task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference: window centred on (cr,cc) takes rows cr-1..cr+1, cols cc-1..cc+1.
   function automatic logic [9*PW-1:0] model_win(input int w, input int cr, input int cc, input bit ramp);
      logic [9*PW-1:0] v;
      int idx;
      v = '0;
      for (int dy = 0; dy < 3; dy++)
         for (int dx = 0; dx < 3; dx++) begin
            idx = (cr-1+dy)*w + (cc-1+dx);
            v[(3*dy+dx)*PW +: PW] = ramp ? PW'(idx % 256) : img[idx];
         end
      return v;
   endfunction

   task automatic push_main();
      exp_t e;
      for (int cr = 1; cr < H-1; cr++)
         for (int cc = 1; cc < W-1; cc++) begin
            e.addr = AW'(cr*W + cc);
            e.win  = model_win(W, cr, cc, 1'b0);
            q.push_back(e);
         end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 0;
            continue;
         end
         if (prev_stall)
            chk(mac_valid && mac_window == prev_win && mac_addr == prev_addr, "stall_hold",
                {mac_valid, mac_addr, mac_window}, {1'b1, prev_addr, prev_win});
         if (mac_valid && !mac_ready) chk(!mem_rd_en, "rd_during_stall", mem_rd_en, 0);
         if (mac_valid && first_rel < 0) first_rel = cyc - t0;
         if (mac_valid && mac_ready) begin
            if (q.size() == 0) chk(1'b0, "unexpected_window", mac_addr, 0);
            else begin
               e = q.pop_front();
               chk(mac_addr == e.addr, "win_addr", mac_addr, e.addr);
               chk(mac_window == e.win, "win_taps", mac_window, e.win);
            end
         end
         if (done) begin
            done_cnt++;
            done_rel = cyc - t0;
         end
         prev_stall = mac_valid && !mac_ready;
         prev_win   = mac_window;
         prev_addr  = mac_addr;
      end
   endtask

   task automatic drive_ready();
      forever begin
         @(posedge clk); #1;
         mac_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   task automatic chk_idle(input string nm);
      chk({busy, done, mem_rd_en, mac_valid, mem_rd_addr, mac_addr, win_count} == '0, nm,
          {busy, done, mem_rd_en, mac_valid, mem_rd_addr, mac_addr, win_count}, 0);
      chk(mac_window == '0, {nm, "_window"}, mac_window, 0);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Called just after an edge: start is high for the current cycle (cycle 0).
   task automatic start_pass();
      push_main();
      start = 1'b1;
      t0 = cyc;
      first_rel = -1;
      done_rel = -1;
      step();
      start = 1'b0;
      chk(busy, "busy_cycle1", busy, 1);
      chk(win_count == '0, "win_count_cycle1", win_count, 0);
   endtask

   task automatic wait_done(input int exp_first, input int exp_done, input bit extra);
      int d0;
      int n;
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < 5000) begin
         start = extra && (cyc - t0 == 100 || cyc - t0 == 400);
         step();
         n++;
      end
      start = 1'b0;
      chk(done_cnt == d0 + 1, "done_seen", done_cnt - d0, 1);
      if (exp_first >= 0) begin
         chk(first_rel == exp_first, "first_valid_cycle", first_rel, exp_first);
         chk(done_rel == exp_done, "done_cycle", done_rel, exp_done);
      end
      chk(win_count == NWIN, "win_count_end", win_count, NWIN);
      chk(q.size() == 0, "windows_left", q.size(), 0);
      chk(!busy, "busy_after_done", busy, 0);
      q.delete();
   endtask

   initial begin
      int d;
      exp_t e;
      bit s_seen;
      rst = 1; start = 0; mac_ready = 1;
      s_rst = 1; s_start = 0; s_ready = 1;
      for (int i = 0; i < (1<<AW); i++) img[i] = '0;
      fork
         monitor();
         drive_ready();
      join_none
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset_state");
      rst = 0; s_rst = 0;

      // ramp image, always ready
      for (int i = 0; i < W*H; i++) img[i] = PW'(i % 256);
      start_pass();
      wait_done(61, 786, 1'b0);

      // ramp image, random backpressure
      rand_ready = 1;
      start_pass();
      wait_done(-1, -1, 1'b0);

      // random image, random backpressure
      for (int i = 0; i < W*H; i++) img[i] = PW'($urandom);
      start_pass();
      wait_done(-1, -1, 1'b0);
      rand_ready = 0;

      // extra start pulses while busy are ignored
      for (int i = 0; i < W*H; i++) img[i] = PW'(i % 256);
      step();
      start_pass();
      wait_done(61, 786, 1'b1);
      d = done_cnt;
      repeat (20) step();
      chk(done_cnt == d, "single_done", done_cnt, d);

      // reset mid-pass, then a clean pass
      start_pass();
      while (cyc - t0 < 300) step();
      d = done_cnt;
      rst = 1;
      step();
      rst = 0;
      chk_idle("reset_mid_pass");
      chk(done_cnt == d, "no_done_after_reset", done_cnt, d);
      q.delete();
      while (cyc - t0 < 310) step();
      start_pass();
      wait_done(61, 786, 1'b0);

      // back-to-back passes, FF then 01
      for (int i = 0; i < W*H; i++) img[i] = 8'hFF;
      start_pass();
      wait_done(61, 786, 1'b0);
      for (int i = 0; i < W*H; i++) img[i] = 8'h01;
      start_pass();
      wait_done(61, 786, 1'b0);

      // small 5x4 instance, ramp image
      for (int cr = 1; cr < SH-1; cr++)
         for (int cc = 1; cc < SW-1; cc++) begin
            e.addr = AW'(cr*SW + cc);
            e.win  = model_win(SW, cr, cc, 1'b1);
            sq.push_back(e);
         end
      s_start = 1;
      step();
      s_start = 0;
      s_seen = 0;
      for (int n = 0; n < 100 && !s_seen; n++) begin
         step();
         if (s_valid) begin
            if (sq.size() == 0) chk(1'b0, "small_unexpected", s_addr, 0);
            else begin
               e = sq.pop_front();
               chk(s_addr == e.addr, "small_addr", s_addr, e.addr);
               chk(s_window == e.win, "small_taps", s_window, e.win);
            end
         end
         if (s_done) s_seen = 1;
      end
      chk(s_seen, "small_done", s_seen, 1);
      step();
      chk(s_win_count == 6, "small_win_count", s_win_count, 6);
      chk(sq.size() == 0, "small_left", sq.size(), 0);
      chk(!s_busy, "small_busy_end", s_busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
